// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, ALUOp codes,
// funct7 constants and the packed control-bundle type.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Datapath control bundle as it crosses into the ID/EX register.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

    // Even parity over a control bundle, for use by protection logic downstream.
    function automatic logic ctrl_parity(input ctrl_t c);
        return ^c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I main decode plus encoding validity check.
// Any encoding that fails the check (or is not a supported opcode)
// collapses to an all-zero bubble.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);

    ctrl_t ctrl_s;
    logic  valid_s;

    // Raw decode of the opcode and the field legality check for that opcode.
    // Legality is only ever granted on positive matches so X/Z fields fall to invalid.
    always_comb begin
        ctrl_s  = '0;
        valid_s = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_op    = ALUOP_R;
                if (funct7 == F7_BASE) begin
                    valid_s = 1'b1;
                end else if ((funct7 == F7_ALT) &&
                             ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    valid_s = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            OP_LOAD: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_read   = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.alu_op     = ALUOP_ADD;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: valid_s = 1'b1;
                    default:                                valid_s = 1'b0;
                endcase
            end
            OP_STORE: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.alu_op    = ALUOP_ADD;
                case (funct3)
                    3'b000, 3'b001, 3'b010: valid_s = 1'b1;
                    default:                valid_s = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                ctrl_s.branch = 1'b1;
                ctrl_s.alu_op = ALUOP_BR;
                case (funct3)
                    3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: valid_s = 1'b1;
                    default:                                        valid_s = 1'b0;
                endcase
            end
            OP_JAL: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.jump      = 1'b1;
                ctrl_s.pc_source = 1'b0;
                ctrl_s.alu_op    = ALUOP_ADD;
                valid_s          = 1'b1;
            end
            OP_IALU: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.alu_op    = ALUOP_I;
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) begin
                            valid_s = 1'b1;
                        end else begin
                            valid_s = 1'b0;
                        end
                    end
                    3'b101: begin
                        if ((funct7 == F7_BASE) || (funct7 == F7_ALT)) begin
                            valid_s = 1'b1;
                        end else begin
                            valid_s = 1'b0;
                        end
                    end
                    3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111: valid_s = 1'b1;
                    default:                                        valid_s = 1'b0;
                endcase
            end
            OP_JALR: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.jump      = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.pc_source = 1'b1;
                ctrl_s.alu_op    = ALUOP_ADD;
                if (funct3 == 3'b000) begin
                    valid_s = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            OP_LUI: begin
                // Operand A is zeroed by the datapath; here LUI is just imm + 0.
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.alu_op    = ALUOP_ADD;
                valid_s          = 1'b1;
            end
            default: begin
                ctrl_s  = '0;
                valid_s = 1'b0;
            end
        endcase
    end

    // Squash illegal encodings into a bubble.
    always_comb begin
        if (valid_s) begin
            ctrl = ctrl_s;
        end else begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder for the ID stage. Decodes combinationally and registers
// the control bits so they line up with the operands at the ID/EX boundary.
module control_unit
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic       Branch,
    output logic       Jump,
    output logic       PCSource,
    output logic [1:0] ALUOp
);

    ctrl_t dec_s;
    ctrl_t ctrl_r;

    ctrl_decode u_decode (
        .opcode (Opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .ctrl   (dec_s)
    );

    // Output register; reset wins over decode and discards the pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_r <= '0;
        end else begin
            ctrl_r <= dec_s;
        end
    end

    assign RegWrite = ctrl_r.reg_write;
    assign MemRead  = ctrl_r.mem_read;
    assign MemWrite = ctrl_r.mem_write;
    assign MemtoReg = ctrl_r.mem_to_reg;
    assign ALUSrc   = ctrl_r.alu_src;
    assign Branch   = ctrl_r.branch;
    assign Jump     = ctrl_r.jump;
    assign PCSource = ctrl_r.pc_source;
    assign ALUOp    = ctrl_r.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps plus random encodings
// compared against a table-driven reference of the decode rules.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] Opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, PCSource;
    logic [1:0] ALUOp;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Opcode   (Opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemtoReg (MemtoReg),
        .ALUSrc   (ALUSrc),
        .Branch   (Branch),
        .Jump     (Jump),
        .PCSource (PCSource),
        .ALUOp    (ALUOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: RegWrite MemRead MemWrite MemtoReg ALUSrc Branch Jump PCSource ALUOp[1:0]
    function automatic logic [9:0] observed();
        return {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, PCSource, ALUOp};
    endfunction

    // Reference: nominal bundle per opcode, gated by the legal-field rules.
    function automatic logic [9:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [9:0] v;
        bit         legal;
        v = 10'b0;
        legal = 1'b0;
        case (op)
            7'b0110011: begin v = 10'b1000000010; legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); end
            7'b0000011: begin v = 10'b1101100000; legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
            7'b0100011: begin v = 10'b0010100000; legal = (f3 <= 3'd2); end
            7'b1100011: begin v = 10'b0000010001; legal = !(f3 == 3'd2 || f3 == 3'd3); end
            7'b1101111: begin v = 10'b1000001000; legal = 1'b1; end
            7'b0010011: begin
                v = 10'b1000100011;
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
                else                 legal = 1'b1;
            end
            7'b1100111: begin v = 10'b1000101100; legal = (f3 == 3'd0); end
            7'b0110111: begin v = 10'b1000100000; legal = 1'b1; end
            default:    begin v = 10'b0; legal = 1'b0; end
        endcase
        return legal ? v : 10'b0;
    endfunction

    task automatic check(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one encoding at the falling edge, clock it in, check just after the edge.
    task automatic step(input string tag, input logic rst, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [9:0] exp);
        @(negedge clk);
        rst_n  = rst;
        Opcode = op;
        funct3 = f3;
        funct7 = f7;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    logic [6:0] ops [8] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b0010011, 7'b1100111, 7'b0110111};

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [9:0] obs;

        rst_n  = 1'b0;
        Opcode = 7'b0110011;
        funct3 = 3'b000;
        funct7 = 7'b0000000;

        // Reset held for two edges with a legal R-type present.
        @(posedge clk); #1;
        check("reset_edge1", 10'b0);
        @(posedge clk); #1;
        check("reset_edge2", 10'b0);
        step("reset_release", 1'b1, 7'b0110011, 3'b000, 7'h00, 10'b1000000010);

        // Legal decode sequence.
        step("rtype",  1'b1, 7'b0110011, 3'b001, 7'h00, 10'b1000000010);
        step("load",   1'b1, 7'b0000011, 3'b010, 7'h00, 10'b1101100000);
        step("store",  1'b1, 7'b0100011, 3'b010, 7'h00, 10'b0010100000);
        step("branch", 1'b1, 7'b1100011, 3'b001, 7'h00, 10'b0000010001);
        step("jal",    1'b1, 7'b1101111, 3'b111, 7'h7f, 10'b1000001000);
        step("ialu",   1'b1, 7'b0010011, 3'b001, 7'h00, 10'b1000100011);
        step("jalr",   1'b1, 7'b1100111, 3'b000, 7'h00, 10'b1000101100);
        step("lui",    1'b1, 7'b0110111, 3'b110, 7'h33, 10'b1000100000);
        step("rtype_sub", 1'b1, 7'b0110011, 3'b000, 7'h20, 10'b1000000010);
        step("srai",   1'b1, 7'b0010011, 3'b101, 7'h20, 10'b1000100011);

        // Illegal encodings.
        step("ill_rtype_alt", 1'b1, 7'b0110011, 3'b001, 7'h20, 10'b0);
        step("ill_load_f3",   1'b1, 7'b0000011, 3'b011, 7'h00, 10'b0);
        step("ill_branch_f3", 1'b1, 7'b1100011, 3'b010, 7'h00, 10'b0);
        step("ill_jalr_f3",   1'b1, 7'b1100111, 3'b001, 7'h00, 10'b0);
        step("ill_slli_f7",   1'b1, 7'b0010011, 3'b001, 7'h20, 10'b0);
        step("ill_opcode",    1'b1, 7'b1111111, 3'b000, 7'h00, 10'b0);
        step("ill_store_f3",  1'b1, 7'b0100011, 3'b100, 7'h00, 10'b0);

        // Hold: a load registered, then inputs change mid-cycle.
        step("hold_load", 1'b1, 7'b0000011, 3'b000, 7'h00, 10'b1101100000);
        #2;
        Opcode = 7'b1100011;
        funct3 = 3'b000;
        #1;
        check("hold_between_edges", 10'b1101100000);
        @(posedge clk); #1;
        check("hold_next_edge", 10'b0000010001);

        // Mid-stream reset discards the pending load, then a store follows.
        step("mid_load", 1'b1, 7'b0000011, 3'b010, 7'h00, 10'b1101100000);
        step("mid_reset", 1'b0, 7'b0000011, 3'b010, 7'h00, 10'b0);
        step("mid_release_store", 1'b1, 7'b0100011, 3'b000, 7'h00, 10'b0010100000);

        // Random encodings against the reference plus exclusivity.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       op = 7'($urandom);
                default: op = ops[$urandom_range(0, 7)];
            endcase
            f3 = 3'($urandom);
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            step("random", 1'b1, op, f3, f7, model(op, f3, f7));
            obs = observed();
            checks++;
            assert (!(obs[8] && obs[7]) && !(obs[4] && obs[3])) else begin
                errors++;
                $error("FAIL exclusivity: observed %b expected no MemRead&MemWrite nor Branch&Jump", obs);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- RV32I main decoder for the pipelined core's ID stage.
- Takes the opcode, funct3 and funct7 fields of the fetched instruction and produces the datapath control bits.
- Control bits are registered so they enter the ID/EX boundary aligned with the operands.
- Unsupported or malformed encodings decode to an all-zero bubble (NOP).

Parameters:
- none (all encodings are fixed constants from the shared package)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- Opcode  input  7  instruction[6:0]
- funct3  input  3  instruction[14:12]
- funct7  input  7  instruction[31:25]
- RegWrite  output  1  write rd in WB
- MemRead  output  1  data-memory read
- MemWrite  output  1  data-memory write
- MemtoReg  output  1  WB selects memory data (1) or ALU/link result (0)
- ALUSrc  output  1  ALU operand B = immediate (1) or rs2 (0)
- Branch  output  1  conditional branch instruction
- Jump  output  1  unconditional jump (JAL/JALR); rd gets PC+4
- PCSource  output  1  jump target = rs1+imm (1, JALR) or PC+imm (0)
- ALUOp  output  2  00 add, 01 branch compare, 10 R-type funct decode, 11 I-type funct decode

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. clk and rst_n are sampled on the rising edge of clk.
- Reset:
  - If rst_n=0 at a rising edge, all outputs become 0 on that edge.
  - Reset has priority over decode.
  - Reset asserted mid-stream discards the pending decode.
- Latency:
  - Inputs are decoded combinationally and registered.
  - Outputs reflect the inputs present at the previous rising edge (1 cycle).
  - Outputs are held stable between edges.
  - No handshake; one decode per cycle.
- Decode table (listed bits are 1, unlisted bits are 0):
  - R-type 0110011: RegWrite; ALUOp=10.
  - Load 0000011: RegWrite, MemRead, MemtoReg, ALUSrc; ALUOp=00.
  - Store 0100011: MemWrite, ALUSrc; ALUOp=00.
  - Branch 1100011: Branch; ALUOp=01.
  - JAL 1101111: RegWrite, Jump; ALUOp=00; PCSource=0.
  - I-ALU 0010011: RegWrite, ALUSrc; ALUOp=11.
  - JALR 1100111: RegWrite, Jump, ALUSrc, PCSource; ALUOp=00.
  - LUI 0110111: RegWrite, ALUSrc; ALUOp=00. Zeroing operand A for LUI is the datapath's job.
- Validity checks (any failure → all outputs 0 next cycle):
  - R-type: funct7=0000000 is valid for any funct3. funct7=0100000 is valid only with funct3 000 or 101.
  - Load: funct3 must be one of 000, 001, 010, 100, 101.
  - Store: funct3 must be one of 000, 001, 010.
  - Branch: funct3 010 and 011 are illegal.
  - JALR: funct3 must be 000.
  - I-ALU shifts: funct3=001 requires funct7=0000000. funct3=101 requires funct7 of 0000000 or 0100000. Other I-ALU funct3 values ignore funct7.
  - JAL and LUI ignore funct3/funct7.
  - Any other opcode, including X/Z inputs, yields all zeros.
- Exclusivity: MemRead and MemWrite are never both 1. Branch and Jump are never both 1.

Decomposition:
- Package rv_ctrl_pkg holds:
  - the opcode localparams (OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_IALU, OP_JALR, OP_LUI);
  - the ALUOp encodings (ALUOP_ADD, ALUOP_BR, ALUOP_R, ALUOP_I);
  - the funct7 constants F7_BASE and F7_ALT.
- Optional single sub-module ctrl_decode: purely combinational decode plus validity check. control_unit wraps it with the reset/output register.

Test Plan:
- Reset: rst_n=0 for 2 edges with Opcode=0110011 → all outputs 0. Release; next edge → RegWrite=1, ALUOp=10.
- Sequence, one per cycle, each output checked one edge after its input:
  - 0110011/001/0000000 → RegWrite, ALUOp=10.
  - 0000011/010 → RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp=00.
  - 0100011/010 → MemWrite, ALUSrc.
  - 1100011/001 → Branch, ALUOp=01.
  - 1101111 → RegWrite, Jump.
  - 0010011/001/0000000 → RegWrite, ALUSrc, ALUOp=11.
  - 1100111/000 → RegWrite, Jump, ALUSrc, PCSource.
  - 0110111 → RegWrite, ALUSrc, ALUOp=00.
- Illegal encodings → all 0:
  - 0110011/001/0100000
  - 0000011/011
  - 1100011/010
  - 1100111/001
  - 0010011/001/0100000
  - Opcode 1111111
- Latency/hold: change Opcode between edges → outputs unchanged until the next rising edge.
- Mid-stream reset: Load decoding, rst_n=0 on one edge → all 0 that edge. Release with Store → MemWrite=1 next edge.
